// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, oversample divisor and receiver state type
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] BAUD_2400 = 2'b00;
    localparam logic [1:0] BAUD_4800 = 2'b01;
    localparam logic [1:0] BAUD_9600 = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Rounded clk count per 16x oversample tick.
    function automatic logic [15:0] baud_div(input int unsigned clk_freq, input int unsigned baud);
        return 16'((clk_freq + 8 * baud) / (16 * baud));
    endfunction

endpackage

// File: rtl/uart_rx_baud16.sv
// uart_rx_baud16: 16x baud oversample tick generator for serial receivers
module uart_rx_baud16
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] baud_rate,
    output logic       tick
);

    localparam logic [15:0] DIV_2400 = baud_div(CLK_FREQ, 2400);
    localparam logic [15:0] DIV_4800 = baud_div(CLK_FREQ, 4800);
    localparam logic [15:0] DIV_9600 = baud_div(CLK_FREQ, 9600);
    localparam logic [15:0] DIV_19200 = baud_div(CLK_FREQ, 19200);

    logic [15:0] div;
    logic [15:0] cnt;

    always_comb begin
        div = baud_rate == BAUD_2400 ? DIV_2400 :
              baud_rate == BAUD_4800 ? DIV_4800 :
              baud_rate == BAUD_9600 ? DIV_9600 : DIV_19200;
        tick = enable && cnt == div - 16'd1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? 16'd0 : cnt + 16'd1;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver with parity and framing checks
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       stop_error
);

    rx_state_t state, state_nx;
    logic       rx_s1, rx_s2, rx_q;
    logic [1:0] baud_l, par_l;
    logic       sb_l, dl_l;
    logic [3:0] os_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, data_al;
    logic       par_bit, stop_acc;
    logic       tick, fall, sample, par_en, last_data, last_stop, finish, perr;

    uart_rx_baud16 #(.CLK_FREQ(CLK_FREQ)) u_baud16 (
        .clk       (clk),
        .arst_n    (arst_n),
        .enable    (state != ST_IDLE),
        .clear     (state == ST_IDLE && fall),
        .baud_rate (baud_l),
        .tick      (tick)
    );

    assign rx_active = state != ST_IDLE;

    // Tick 7 of every 16 is the middle of a bit, counted from the start edge.
    always_comb begin
        fall = rx_q & ~rx_s2;
        sample = tick && os_cnt == 4'd7;
        par_en = par_l == PAR_ODD || par_l == PAR_EVEN;
        last_data = bit_cnt == (dl_l ? 3'd7 : 3'd6);
        last_stop = bit_cnt == {2'b00, sb_l};
        finish = state == ST_STOP && sample && last_stop;
        data_al = dl_l ? shreg : {1'b0, shreg[7:1]};
        perr = par_en && ((^data_al ^ par_bit) == (par_l == PAR_EVEN));
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = fall ? ST_START : ST_IDLE;
            ST_START:  state_nx = !sample ? ST_START : rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:   state_nx = !(sample && last_data) ? ST_DATA : par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: state_nx = sample ? ST_STOP : ST_PARITY;
            ST_STOP:   state_nx = finish ? ST_IDLE : ST_STOP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q <= 1'b1;
            baud_l <= '0;
            par_l <= '0;
            sb_l <= 1'b0;
            dl_l <= 1'b0;
            os_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            par_bit <= 1'b0;
            stop_acc <= 1'b0;
            rx_done <= 1'b0;
            data_out <= '0;
            parity_error <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q <= rx_s2;
            rx_done <= finish;
            if (state == ST_IDLE && fall) begin
                baud_l <= baud_rate;
                par_l <= parity_type;
                sb_l <= stop_bits;
                dl_l <= data_length;
                os_cnt <= '0;
                bit_cnt <= '0;
                stop_acc <= 1'b0;
            end else if (tick) begin
                os_cnt <= os_cnt + 4'd1;
            end
            if (sample && state == ST_DATA) begin
                shreg <= {rx_s2, shreg[7:1]};
                bit_cnt <= last_data ? 3'd0 : bit_cnt + 3'd1;
            end
            if (sample && state == ST_PARITY)
                par_bit <= rx_s2;
            if (sample && state == ST_STOP) begin
                stop_acc <= stop_acc | ~rx_s2;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (finish) begin
                data_out <= data_al;
                parity_error <= perr;
                stop_error <= stop_acc | ~rx_s2;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at a 2 MHz clock (divisors 52/26/13/7)
module tb_uart_rx;

    localparam int BT_2400 = 832;
    localparam int BT_4800 = 416;
    localparam int BT_9600 = 208;
    localparam int BT_19200 = 112;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] baud_rate = 2'b00;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic       data_length = 1'b1;
    logic [7:0] data_out;
    logic       rx_active, rx_done, parity_error, stop_error;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int act_cnt = 0;
    logic [7:0] got [4];

    uart_rx #(.CLK_FREQ(2_000_000)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .rx           (rx),
        .baud_rate    (baud_rate),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .data_out     (data_out),
        .rx_active    (rx_active),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) begin
            if (done_cnt < 4)
                got[done_cnt] = data_out;
            done_cnt++;
        end
        if (rx_active)
            act_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drives f[0] first, each bit held bt clocks, then returns the line to idle.
    task automatic send(input logic [11:0] f, input int n, input int bt);
        for (int i = 0; i < n; i++) begin
            rx = f[i];
            repeat (bt) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        act_cnt = 0;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_data", data_out, 0);
        check("rst_active", rx_active, 0);
        check("rst_done", rx_done, 0);
        check("rst_perr", parity_error, 0);
        check("rst_serr", stop_error, 0);
        arst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 9600 8E1, 0xD5 with correct even parity bit 1
        baud_rate = 2'b10; parity_type = 2'b10; stop_bits = 1'b0; data_length = 1'b1;
        clear_counts();
        send({1'b1, 1'b1, 1'b1, 8'hD5, 1'b0}, 11, BT_9600);
        repeat (2 * BT_9600) @(negedge clk);
        check("t1_done", done_cnt, 1);
        check("t1_data", data_out, 8'hD5);
        check("t1_perr", parity_error, 0);
        check("t1_serr", stop_error, 0);
        check("t1_active_len", act_cnt >= 2180 && act_cnt <= 2190, 1);

        // 19200 7O2, 0x55 with wrong parity bit 0
        baud_rate = 2'b11; parity_type = 2'b01; stop_bits = 1'b1; data_length = 1'b0;
        clear_counts();
        send({1'b1, 1'b1, 1'b1, 1'b0, 7'h55, 1'b0}, 11, BT_19200);
        repeat (2 * BT_19200) @(negedge clk);
        check("t2_done", done_cnt, 1);
        check("t2_data", data_out, 8'h55);
        check("t2_perr", parity_error, 1);
        check("t2_serr", stop_error, 0);

        // 4800 8N1, 0x3C with a low stop bit, then a clean 0xA5
        baud_rate = 2'b01; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        clear_counts();
        send({2'b11, 1'b0, 8'h3C, 1'b0}, 10, BT_4800);
        repeat (2 * BT_4800) @(negedge clk);
        check("t3_data", data_out, 8'h3C);
        check("t3_serr", stop_error, 1);
        check("t3_perr", parity_error, 0);
        send({2'b11, 1'b1, 8'hA5, 1'b0}, 10, BT_4800);
        repeat (2 * BT_4800) @(negedge clk);
        check("t3b_done", done_cnt, 2);
        check("t3b_data", data_out, 8'hA5);
        check("t3b_serr", stop_error, 0);
        check("t3b_perr", parity_error, 0);

        // 4-tick glitch at 4800 (tick = 26 clk)
        clear_counts();
        rx = 1'b0;
        repeat (4 * 26) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BT_4800) @(negedge clk);
        check("t4_done", done_cnt, 0);
        check("t4_data", data_out, 8'hA5);
        check("t4_serr", stop_error, 0);
        check("t4_active_short", act_cnt > 0 && act_cnt < BT_4800, 1);

        // 2400 8N1 back-to-back, config disturbed during the first frame
        baud_rate = 2'b00; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        clear_counts();
        fork
            begin
                send({2'b11, 1'b1, 8'h01, 1'b0}, 10, BT_2400);
                send({2'b11, 1'b1, 8'hFE, 1'b0}, 10, BT_2400);
            end
            begin
                repeat (3 * BT_2400) @(negedge clk);
                baud_rate = 2'b11; parity_type = 2'b10; data_length = 1'b0;
                repeat (4 * BT_2400) @(negedge clk);
                baud_rate = 2'b00; parity_type = 2'b00; data_length = 1'b1;
            end
        join
        repeat (2 * BT_2400) @(negedge clk);
        check("t5_done", done_cnt, 2);
        check("t5_first", got[0], 8'h01);
        check("t5_second", got[1], 8'hFE);
        check("t5_perr", parity_error, 0);

        // reset during DATA at 9600 8N1, then a fresh 0x81
        baud_rate = 2'b10;
        clear_counts();
        send({2'b11, 1'b1, 8'hFF, 1'b0}, 5, BT_9600);
        check("t6_active_pre", rx_active, 1);
        arst_n = 1'b0;
        #1;
        check("t6_rst_data", data_out, 0);
        check("t6_rst_active", rx_active, 0);
        check("t6_rst_done", rx_done, 0);
        check("t6_rst_perr", parity_error, 0);
        check("t6_rst_serr", stop_error, 0);
        repeat (10) @(negedge clk);
        arst_n = 1'b1;
        repeat (2 * BT_9600) @(negedge clk);
        send({2'b11, 1'b1, 8'h81, 1'b0}, 10, BT_9600);
        repeat (2 * BT_9600) @(negedge clk);
        check("t6_done", done_cnt, 1);
        check("t6_data", data_out, 8'h81);
        check("t6_serr", stop_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver and the receive-side counterpart of the team's UART transmitter. It uses the same configuration inputs (baud_rate, parity_type, stop_bits, data_length) and the same line format, so a transmitter and receiver with identical settings interoperate. It oversamples the line at 16× baud from the 50 MHz system clock and presents each received character with a single-cycle done strobe plus parity and framing status.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz; sets the oversample divisors.
- clk  input  1  system clock.
- arst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk; idles high.
- baud_rate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200 baud.
- parity_type  input  2  parity mode: 00=none, 01=odd, 10=even, 11=none.
- stop_bits  input  1  stop bit count: 0=one, 1=two.
- data_length  input  1  data bits: 0=7, 1=8.
- data_out  output  8  last received character; bit 7 is 0 in 7-bit mode.
- rx_active  output  1  high while a frame is being received.
- rx_done  output  1  one-clk pulse when a frame completes.
- parity_error  output  1  parity mismatch on the last frame.
- stop_error  output  1  a stop bit sampled low on the last frame (framing error).

## Operation
- rx passes through a 2-FF synchronizer. Both flops reset to 1.
- Oversample tick period = round(CLK_FREQ / (16·baud)), which gives 1302, 651, 326 and 163 clk.
- The tick counter runs only while the receiver is out of IDLE and restarts from 0 on start detection.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- **IDLE:** a synchronized falling edge moves the FSM to START. On that edge, baud_rate, parity_type, stop_bits and data_length are latched. Config changes during a frame have no effect until the next frame.
- **START:** the line is sampled at tick 7, the bit middle.
  - If the sample is high, it was a glitch: return to IDLE, with no rx_done and no status change.
  - If low, go to DATA.
- **DATA:** the line is sampled every 16 ticks at mid-bit, LSB first, into a shift register. After 7 or 8 bits (per latched data_length), go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY:** sample one bit. The error condition is:
  - even mode: XOR of the data bits and the parity bit is 1;
  - odd mode: that XOR is 0.
  - Only the active data bits (7 or 8) are included.
- **STOP:** sample one or two stop bits. Any low sample sets the frame's stop error. After the final stop sample, go to IDLE.
- **Frame completion:** data_out, parity_error and stop_error update and rx_done pulses together. The outputs hold until the next completed frame.
- **Back-to-back frames:** a start edge right after the last stop mid-sample is accepted. The FSM is in IDLE by then.
- **Break condition:** a line held low gives a frame with stop_error=1 and data 0x00. The receiver then waits in IDLE for a high-then-low edge.
- **Reset mid-frame:** the frame is aborted. All outputs go to reset values and the FSM goes to IDLE with no rx_done.

## Timing
- All outputs reset to 0.
- rx_active rises 1 clk after the start edge is detected (3 clk after the rx pin falls, due to the synchronizer). It falls in the same cycle rx_done pulses.
- rx_done is high for exactly 1 clk, one cycle after the final stop-bit mid sample. Its latency from the start-bit falling edge is about (frame_bits − 0.5) bit times + 3 clk.
- Mid-bit sampling tolerates ±3 % aggregate baud mismatch between transmitter and receiver.
- Frame lengths in bits (start + data + parity + stop):
  - minimum: 1+7+0+1 = 9;
  - maximum: 1+8+1+2 = 12.

## Structure
- **Package uart_pkg** holds:
  - parity encodings PAR_NONE, PAR_ODD, PAR_EVEN;
  - baud select codes;
  - the divisor function of CLK_FREQ and baud;
  - the rx state enum.
- **Sub-module uart_rx_baud16** generates the 16× tick.
  - Inputs: clk, arst_n, enable, clear, baud_rate.
  - Output: tick.
  - It also serves any future oversampling receivers.
- The FSM, shift register, bit counter and parity checker are in uart_rx. The parity checker is combinational over the shift register.

## Test plan
- **9600 baud, 8 data bits, even parity, 1 stop bit:** send 0xD5 with parity bit 1 → one rx_done, data_out=0xD5, parity_error=0, stop_error=0. rx_active is high for about 10.5 bit times.
- **19200 baud, 7 data bits, odd parity, 2 stop bits:** send 0x55 with a deliberately wrong parity bit → data_out=0x55 with bit 7 = 0, parity_error=1.
- **Framing error:** 4800 baud, 8N1, stop bit driven low for 0x3C → data_out=0x3C, stop_error=1. A following valid 0xA5 frame → both error flags 0.
- **Glitch rejection:** a 4-tick low pulse on rx while in IDLE → no rx_done, rx_active high for less than 1 bit time, outputs unchanged.
- **Back-to-back and mid-frame changes:** two 8N1 frames 0x01 then 0xFE at 2400 baud with no idle gap, and baud_rate changed during the first frame → both received correctly, with two rx_done pulses.
- **Reset mid-frame:** assert arst_n low during DATA → all outputs 0 immediately. After release, a fresh 0x81 frame is received correctly.
